// File: rtl/branch_resolve_queue_if.sv
// Fetch/predictor/execute-side signal bundle for branch_resolve_queue.
// slave = the queue itself, master = the pipeline/predictor environment driving it.
interface branch_resolve_queue_if #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic            fetchBranch;
    logic [PC_W-1:0] fetchPc;
    logic            stall;
    logic            predict;
    logic [PC_W-1:0] predictPc;
    logic            prediction;
    logic            predTaken;
    logic            predValid;
    logic            resolveValid;
    logic            resolveTaken;
    logic            flush;
    logic            update;
    logic [PC_W-1:0] updatePc;
    logic            reality;
    logic            mispredict;
    logic [CW-1:0]   count;
    logic            underflow;
    logic [15:0]     branchCount;
    logic [15:0]     mispredictCount;

    modport slave (
        input  fetchBranch, fetchPc, prediction, resolveValid, resolveTaken, flush,
        output stall, predict, predictPc, predTaken, predValid, update, updatePc,
               reality, mispredict, count, underflow, branchCount, mispredictCount
    );

    modport master (
        output fetchBranch, fetchPc, prediction, resolveValid, resolveTaken, flush,
        input  stall, predict, predictPc, predTaken, predValid, update, updatePc,
               reality, mispredict, count, underflow, branchCount, mispredictCount
    );
endinterface

// File: rtl/branch_resolve_queue.sv
// In-order queue of outstanding GShare predictions, retired by execute-stage resolves.
// Optional macro STATS_EN adds saturating branch/mispredict counters (tied to 0 otherwise).
module branch_resolve_queue #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
) (
    input logic                  clk,
    input logic                  reset,
    branch_resolve_queue_if.slave bq
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [PC_W-1:0]  pc_mem [DEPTH];
    logic [DEPTH-1:0] pred_mem;
    logic [AW-1:0]    head;
    logic [AW-1:0]    tail;
    logic [CW-1:0]    count;
    logic             pending;
    logic [PC_W-1:0]  pending_pc;
    logic             update_q;
    logic [PC_W-1:0]  update_pc_q;
    logic             reality_q;
    logic             mispredict_q;
    logic             underflow_q;

    logic             stall;
    logic             predict;
    logic             push;
    logic             pop;
    logic [CW:0]      occupancy;

    // The in-flight request already owns a slot, so it counts toward fullness.
    always_comb begin
        occupancy = {1'b0, count} + {{CW{1'b0}}, pending};
        stall     = occupancy >= (CW+1)'(DEPTH);
        predict   = bq.fetchBranch & ~stall & ~bq.flush;
        push      = pending & ~bq.flush;
        pop       = bq.resolveValid & (count != '0) & ~bq.flush;
    end

    always_ff @(posedge clk) begin
        if (push && !reset) begin
            pc_mem[tail]   <= pending_pc;
            pred_mem[tail] <= bq.prediction;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            pending      <= 1'b0;
            pending_pc   <= '0;
            update_q     <= 1'b0;
            update_pc_q  <= '0;
            reality_q    <= 1'b0;
            mispredict_q <= 1'b0;
            underflow_q  <= 1'b0;
        end else if (bq.flush) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            pending      <= 1'b0;
            update_q     <= 1'b0;
            mispredict_q <= 1'b0;
        end else begin
            pending <= predict;
            if (predict)
                pending_pc <= bq.fetchPc;
            if (push)
                tail <= tail + AW'(1);
            if (pop) begin
                head         <= head + AW'(1);
                update_pc_q  <= pc_mem[head];
                reality_q    <= bq.resolveTaken;
                mispredict_q <= bq.resolveTaken != pred_mem[head];
            end else begin
                mispredict_q <= 1'b0;
            end
            update_q <= pop;
            count    <= count + CW'(push) - CW'(pop);
            if (bq.resolveValid && count == '0)
                underflow_q <= 1'b1;
        end
    end

`ifdef STATS_EN
    logic [15:0] branch_cnt;
    logic [15:0] mispredict_cnt;

    // Counts survive flush; only reset clears them.
    always_ff @(posedge clk) begin
        if (reset) begin
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
        end else begin
            if (update_q && branch_cnt != 16'hFFFF)
                branch_cnt <= branch_cnt + 16'd1;
            if (mispredict_q && mispredict_cnt != 16'hFFFF)
                mispredict_cnt <= mispredict_cnt + 16'd1;
        end
    end

    assign bq.branchCount     = branch_cnt;
    assign bq.mispredictCount = mispredict_cnt;
`else
    assign bq.branchCount     = 16'd0;
    assign bq.mispredictCount = 16'd0;
`endif

    assign bq.stall      = stall;
    assign bq.predict    = predict;
    assign bq.predictPc  = bq.fetchPc;
    assign bq.predValid  = pending;
    assign bq.predTaken  = pending & bq.prediction;
    assign bq.update     = update_q;
    assign bq.updatePc   = update_pc_q;
    assign bq.reality    = reality_q;
    assign bq.mispredict = mispredict_q;
    assign bq.count      = count;
    assign bq.underflow  = underflow_q;
endmodule

// File: tb/tb_branch_resolve_queue.sv
// Randomized and directed bench for branch_resolve_queue against a queue-based reference model.
module tb_branch_resolve_queue;
    localparam int DEPTH = 4;
    localparam int PC_W  = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    branch_resolve_queue_if #(.DEPTH(DEPTH), .PC_W(PC_W)) bq ();
    branch_resolve_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bq    (bq)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct packed {
        logic [31:0] pc;
        logic        pred;
    } ent_t;

    ent_t        q[$];
    logic        m_pending;
    logic [31:0] m_ppc;
    logic        m_update, m_real, m_misp, m_underflow;
    logic [31:0] m_upc;
    int          m_bc, m_mc;

    logic        i_fb, i_pr, i_rv, i_rt, i_fl, i_rs;
    logic [31:0] i_pc;

    function automatic void model_reset();
        q.delete();
        m_pending   = 1'b0;
        m_ppc       = '0;
        m_update    = 1'b0;
        m_upc       = '0;
        m_real      = 1'b0;
        m_misp      = 1'b0;
        m_underflow = 1'b0;
        m_bc        = 0;
        m_mc        = 0;
    endfunction

    function automatic logic m_stall();
        return (q.size() + int'(m_pending)) >= DEPTH;
    endfunction

    task automatic compare_all();
        logic exp_predict;
        exp_predict = i_fb && !m_stall() && !i_fl;
        chk("stall",      32'(bq.stall),      32'(m_stall()));
        chk("predict",    32'(bq.predict),    32'(exp_predict));
        chk("predictPc",  bq.predictPc,       i_pc);
        chk("predValid",  32'(bq.predValid),  32'(m_pending));
        chk("predTaken",  32'(bq.predTaken),  32'(m_pending & i_pr));
        chk("count",      32'(bq.count),      32'(q.size()));
        chk("update",     32'(bq.update),     32'(m_update));
        chk("updatePc",   bq.updatePc,        m_upc);
        chk("reality",    32'(bq.reality),    32'(m_real));
        chk("mispredict", 32'(bq.mispredict), 32'(m_misp));
        chk("underflow",  32'(bq.underflow),  32'(m_underflow));
`ifdef STATS_EN
        chk("branchCount",     32'(bq.branchCount),     32'(m_bc));
        chk("mispredictCount", 32'(bq.mispredictCount), 32'(m_mc));
`else
        chk("branchCount",     32'(bq.branchCount),     32'd0);
        chk("mispredictCount", 32'(bq.mispredictCount), 32'd0);
`endif
    endtask

    // Advances the model across one clock edge using the inputs held during that cycle.
    function automatic void model_step();
        bit   was_empty;
        bit   do_pred;
        ent_t e;
        if (i_rs) begin
            model_reset();
            return;
        end
        if (m_update && m_bc < 16'hFFFF) m_bc++;
        if (m_misp && m_mc < 16'hFFFF) m_mc++;
        if (i_fl) begin
            q.delete();
            m_pending = 1'b0;
            m_update  = 1'b0;
            m_misp    = 1'b0;
            return;
        end
        do_pred   = i_fb && !m_stall();
        was_empty = (q.size() == 0);
        if (i_rv && !was_empty) begin
            e        = q.pop_front();
            m_update = 1'b1;
            m_upc    = e.pc;
            m_real   = i_rt;
            m_misp   = (i_rt != e.pred);
        end else begin
            m_update = 1'b0;
            m_misp   = 1'b0;
        end
        if (i_rv && was_empty) m_underflow = 1'b1;
        if (m_pending) q.push_back('{pc: m_ppc, pred: i_pr});
        m_pending = do_pred;
        if (do_pred) m_ppc = i_pc;
    endfunction

    task automatic step(input logic fb, input logic [31:0] pc, input logic pr,
                        input logic rv, input logic rt, input logic fl, input logic rs);
        i_fb = fb; i_pc = pc; i_pr = pr; i_rv = rv; i_rt = rt; i_fl = fl; i_rs = rs;
        bq.fetchBranch  = fb;
        bq.fetchPc      = pc;
        bq.prediction   = pr;
        bq.resolveValid = rv;
        bq.resolveTaken = rt;
        bq.flush        = fl;
        reset           = rs;
        @(negedge clk);
        compare_all();
        @(posedge clk);
        model_step();
        #1;
    endtask

    initial begin
        i_fb = 0; i_pc = 0; i_pr = 0; i_rv = 0; i_rt = 0; i_fl = 0; i_rs = 1;
        bq.fetchBranch = 0; bq.fetchPc = 0; bq.prediction = 0;
        bq.resolveValid = 0; bq.resolveTaken = 0; bq.flush = 0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        step(0, 0, 0, 0, 0, 0, 1);

        // single branch, correctly predicted not-taken
        step(1, 32'h1, 0, 0, 0, 0, 0);
        step(0, 32'h0, 0, 0, 0, 0, 0);
        step(0, 32'h0, 0, 1, 0, 0, 0);
        chk("tp_single_update", 32'(bq.update), 32'd1);
        chk("tp_single_upc", bq.updatePc, 32'h1);
        chk("tp_single_misp", 32'(bq.mispredict), 32'd0);
        step(0, 32'h0, 0, 0, 0, 0, 0);

        // mispredict: predicted not-taken, resolved taken
        step(1, 32'h2, 0, 0, 0, 0, 0);
        step(0, 32'h0, 0, 0, 0, 0, 0);
        step(0, 32'h0, 0, 1, 1, 0, 0);
        chk("tp_misp_pulse", 32'(bq.mispredict), 32'd1);
        chk("tp_misp_upc", bq.updatePc, 32'h2);
        step(0, 32'h0, 0, 0, 0, 0, 0);
        chk("tp_misp_single_cycle", 32'(bq.mispredict), 32'd0);

        // fill, stall, free one slot, then drain in order
        for (int p = 1; p <= 4; p++) step(1, 32'(p), p[0], 0, 0, 0, 0);
        step(1, 32'h5, 1, 0, 0, 0, 0);
        step(1, 32'h5, 0, 1, 1, 0, 0);
        step(1, 32'h5, 0, 0, 0, 0, 0);
        step(0, 32'h0, 1, 0, 0, 0, 0);
        for (int r = 0; r < 6; r++) step(0, 32'h0, 0, 1, r[0], 0, 0);

        // simultaneous push/pop at count=2
        step(1, 32'h10, 0, 0, 0, 0, 0);
        step(1, 32'h11, 1, 0, 0, 0, 0);
        step(1, 32'h12, 0, 0, 0, 0, 0);
        step(0, 32'h0, 1, 1, 0, 0, 0);
        chk("tp_pushpop_upc", bq.updatePc, 32'h10);
        for (int r = 0; r < 3; r++) step(0, 32'h0, 0, 1, 1, 0, 0);

        // flush with 3 entries and a pending request, resolve ignored
        for (int p = 0; p < 4; p++) step(1, 32'h20 + 32'(p), 1, 0, 0, 0, 0);
        step(0, 32'h0, 1, 1, 1, 1, 0);
        step(0, 32'h0, 1, 0, 0, 0, 0);
        chk("tp_flush_count", 32'(bq.count), 32'd0);

        // underflow on empty queue, sticky until reset
        step(0, 32'h0, 0, 1, 0, 0, 0);
        step(0, 32'h0, 0, 0, 0, 0, 0);
        chk("tp_underflow", 32'(bq.underflow), 32'd1);
        step(0, 32'h0, 0, 0, 0, 0, 1);
        step(0, 32'h0, 0, 0, 0, 0, 0);

        repeat (3000)
            step($urandom_range(0, 9) < 7, $urandom, 1'($urandom),
                 $urandom_range(0, 9) < 4, 1'($urandom),
                 $urandom_range(0, 49) == 0, $urandom_range(0, 299) == 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
